// File: rtl/oam_dma_bridge.sv
// OAM DMA bridge: sits between the CPU and the memory bus. Passes CPU
// accesses through when idle. A write to the DMA trigger register starts a
// block copy of DMA_LEN bytes from page {src_page,00} into OAM. The copy
// alternates read and write cycles. While it runs, the CPU can only reach
// high RAM (FF80-FFFE) and the trigger register.
module oam_dma_bridge #(
    parameter logic [15:0] DMA_REG  = 16'hFF46,
    parameter int          DMA_LEN  = 160,
    parameter logic [15:0] OAM_BASE = 16'hFE00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [7:0]  cpu_data_out,
    output logic [7:0]  cpu_data_in,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    output logic        mem_wr_en,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE, START, RD, WR} state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t     state, state_next;
    logic [7:0] idx, idx_next;
    logic [7:0] src_page, src_page_next;
    logic [7:0] data_latch, data_latch_next;

    logic       cpu_wr, cpu_rd, cpu_any;
    logic       is_dma_reg, is_hram;
    logic       trigger, cpu_bus, freeze;
    logic [7:0] eff_page;

    // A simultaneous read and write strobe counts as a write only.
    assign cpu_wr     = cpu_wr_en;
    assign cpu_rd     = cpu_rd_en & ~cpu_wr_en;
    assign cpu_any    = cpu_wr | cpu_rd;
    assign is_dma_reg = (cpu_addr == DMA_REG);
    assign is_hram    = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    assign trigger    = cpu_wr & is_dma_reg;

    assign dma_active = (state != IDLE);

    // The CPU owns the bus when idle. During a transfer it owns the bus
    // only for high RAM, and the DMA engine stalls for that cycle.
    assign cpu_bus    = cpu_any && !is_dma_reg && (!dma_active || is_hram);
    assign freeze     = dma_active && cpu_bus;

    // Pages E0-FF are echo RAM and fold down onto C0-DF.
    assign eff_page   = (src_page >= 8'hE0) ? (src_page & 8'hDF) : src_page;

    // State register and datapath registers.
    // NOTE: all control registers get a reset value, so the engine can never
    // wake up mid-transfer with stale idx/state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= 8'h00;
            src_page   <= 8'hFF;
            data_latch <= 8'h00;
        end else begin
            // NOTE: non-blocking assignments, so every register samples
            // pre-edge values regardless of statement order.
            state      <= state_next;
            idx        <= idx_next;
            src_page   <= src_page_next;
            data_latch <= data_latch_next;
        end
    end

    // Next-state logic: trigger beats everything, then HRAM stall, then sequencing.
    always_comb begin
        // NOTE: hold-current defaults first, so no path through this block
        // leaves a variable unassigned (which would infer a latch).
        state_next      = state;
        idx_next        = idx;
        src_page_next   = src_page;
        data_latch_next = data_latch;

        if (trigger) begin
            src_page_next = cpu_data_out;
            idx_next      = 8'h00;
            state_next    = START;
        end else if (!freeze) begin
            unique case (state)
                IDLE:  ;
                START: state_next = RD;
                RD: begin
                    data_latch_next = mem_rdata;
                    state_next      = WR;
                end
                WR: begin
                    if (idx == LAST_IDX) begin
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx + 8'd1;
                        state_next = RD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Bus mux: CPU passthrough, DMA read, DMA write, or nothing selected.
    // A trigger in the same cycle suppresses the DMA cycle, which aborts the
    // in-flight byte.
    always_comb begin
        mem_addr  = 16'h0000;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_wdata = 8'h00;

        if (cpu_bus) begin
            mem_addr  = cpu_addr;
            mem_rd_en = cpu_rd;
            mem_wr_en = cpu_wr;
            mem_wdata = cpu_data_out;
        end else if (!trigger && state == RD) begin
            mem_addr  = {eff_page, idx};
            mem_rd_en = 1'b1;
        end else if (!trigger && state == WR) begin
            mem_addr  = OAM_BASE + {8'h00, idx};
            mem_wr_en = 1'b1;
            mem_wdata = data_latch;
        end
    end

    // CPU read data: trigger register, passthrough, or open-bus FF during lockout.
    always_comb begin
        if (is_dma_reg) begin
            cpu_data_in = src_page;
        end else if (!dma_active || is_hram) begin
            cpu_data_in = mem_rdata;
        end else begin
            cpu_data_in = 8'hFF;
        end
    end

endmodule

// File: tb/tb_oam_dma_bridge.sv
// Directed bench for oam_dma_bridge with a behavioural 64 KiB memory and a
// scoreboard queue of expected values.
module tb_oam_dma_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rd_en;
    logic        cpu_wr_en;
    logic [7:0]  cpu_data_out;
    logic [7:0]  cpu_data_in;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic        mem_wr_en;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        dma_active;

    always #5 clk = ~clk;

    oam_dma_bridge dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_addr     (cpu_addr),
        .cpu_rd_en    (cpu_rd_en),
        .cpu_wr_en    (cpu_wr_en),
        .cpu_data_out (cpu_data_out),
        .cpu_data_in  (cpu_data_in),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .dma_active   (dma_active)
    );

    // Memory model: combinational read, write on rising edge. The preload
    // port lets the bench initialise contents through the same process.
    logic [7:0]  mem [0:65535];
    logic        pl_en = 1'b0;
    logic [15:0] pl_addr = 16'h0000;
    logic [7:0]  pl_data = 8'h00;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_wr_en)  mem[mem_addr] <= mem_wdata;
        else if (pl_en) mem[pl_addr]  <= pl_data;
    end

    int          vectors     = 0;
    int          miscompares = 0;
    int          dma_cycles  = 0;
    logic [15:0] sb_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input logic [15:0] v);
        sb_q.push_back(v);
    endtask

    task automatic pop_check(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s: got %h expected <scoreboard empty>", tag, obs);
        end else begin
            e = sb_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [7:0] d);
        pl_en   = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(posedge clk); #1;
        pl_en   = 1'b0;
    endtask

    task automatic fill_oam(input logic [7:0] v);
        for (int i = 0; i < 160; i++) poke(16'hFE00 + 16'(i), v);
    endtask

    task automatic idle_bus();
        cpu_addr     = 16'h0000;
        cpu_rd_en    = 1'b0;
        cpu_wr_en    = 1'b0;
        cpu_data_out = 8'h00;
    endtask

    // One clock; count DMA-active cycles and check bus strobe exclusivity.
    task automatic tick();
        @(posedge clk); #1;
        if (dma_active) dma_cycles++;
        check("rd_wr_excl", {15'b0, mem_rd_en & mem_wr_en}, 16'h0000);
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        cpu_addr     = a;
        cpu_data_out = d;
        cpu_wr_en    = 1'b1;
        cpu_rd_en    = 1'b0;
        tick();
        idle_bus();
    endtask

    task automatic cpu_read_check(input string tag, input logic [15:0] a, input logic [7:0] exp);
        cpu_addr  = a;
        cpu_rd_en = 1'b1;
        expect_val({8'h00, exp});
        #1;
        pop_check(tag, {8'h00, cpu_data_in});
        idle_bus();
    endtask

    task automatic wait_idle(input string tag, input int exp_cycles);
        int guard = 0;
        while (dma_active && guard < 2000) begin
            tick();
            guard++;
        end
        check("dma_timeout", {15'b0, dma_active}, 16'h0000);
        check(tag, 16'(dma_cycles), 16'(exp_cycles));
    endtask

    initial begin
        idle_bus();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        // Reset state, checked before any clock edge.
        check("rst_active", {15'b0, dma_active}, 16'h0000);
        cpu_read_check("rst_ff46", 16'hFF46, 8'hFF);
        check("idle_addr0", mem_addr, 16'h0000);
        check("idle_wdata0", {8'h00, mem_wdata}, 16'h0000);
        check("idle_rd0", {15'b0, mem_rd_en}, 16'h0000);
        @(posedge clk); #1;
        rst = 1'b1;

        // Idle passthrough.
        poke(16'h1234, 8'h12);
        cpu_read_check("pass_rd", 16'h1234, 8'h12);
        cpu_write(16'hC000, 8'hAB);
        check("pass_wr", {8'h00, mem[16'hC000]}, 16'h00AB);
        cpu_addr = 16'hC001; cpu_data_out = 8'h5A; cpu_rd_en = 1'b1; cpu_wr_en = 1'b1;
        #1;
        check("both_wr_en", {15'b0, mem_wr_en}, 16'h0001);
        check("both_rd_en", {15'b0, mem_rd_en}, 16'h0000);
        tick();
        idle_bus();
        check("both_mem", {8'h00, mem[16'hC001]}, 16'h005A);

        // Full transfer from page C0.
        for (int i = 0; i < 160; i++) poke(16'hC000 + 16'(i), 8'(i));
        fill_oam(8'hEE);
        dma_cycles = 0;
        cpu_write(16'hFF46, 8'hC0);
        wait_idle("full_len", 321);
        for (int i = 0; i < 160; i++) expect_val(16'(i));
        for (int i = 0; i < 160; i++) pop_check("full_oam", {8'h00, mem[16'hFE00 + 16'(i)]});
        cpu_read_check("full_ff46", 16'hFF46, 8'hC0);

        // Lockout and high-RAM access during a transfer.
        poke(16'hC100, 8'h33);
        poke(16'hFF80, 8'h00);
        fill_oam(8'hEE);
        dma_cycles = 0;
        cpu_write(16'hFF46, 8'hC0);
        repeat (10) tick();
        cpu_read_check("lock_rd", 16'hC000, 8'hFF);
        cpu_read_check("lock_ff46", 16'hFF46, 8'hC0);
        cpu_write(16'hC100, 8'h55);
        cpu_write(16'hFF80, 8'h77);
        wait_idle("hram_len", 322);
        check("lock_drop", {8'h00, mem[16'hC100]}, 16'h0033);
        check("hram_wr", {8'h00, mem[16'hFF80]}, 16'h0077);
        for (int i = 0; i < 160; i++) expect_val(16'(i));
        for (int i = 0; i < 160; i++) pop_check("hram_oam", {8'h00, mem[16'hFE00 + 16'(i)]});

        // Retrigger mid-transfer with a new page.
        for (int i = 0; i < 160; i++) poke(16'hD000 + 16'(i), 8'(255 - i));
        fill_oam(8'hEE);
        dma_cycles = 0;
        cpu_write(16'hFF46, 8'hC0);
        repeat (49) tick();
        cpu_write(16'hFF46, 8'hD0);
        wait_idle("retrig_len", 371);
        for (int i = 0; i < 160; i++) expect_val(16'(255 - i));
        for (int i = 0; i < 160; i++) pop_check("retrig_oam", {8'h00, mem[16'hFE00 + 16'(i)]});

        // Echo-RAM fold: page E1 reads from C1.
        for (int i = 0; i < 160; i++) poke(16'hC100 + 16'(i), 8'(i) ^ 8'h5A);
        for (int i = 0; i < 160; i++) poke(16'hE100 + 16'(i), 8'h99);
        fill_oam(8'hEE);
        dma_cycles = 0;
        cpu_write(16'hFF46, 8'hE1);
        wait_idle("echo_len", 321);
        for (int i = 0; i < 160; i++) expect_val({8'h00, 8'(i) ^ 8'h5A});
        for (int i = 0; i < 160; i++) pop_check("echo_oam", {8'h00, mem[16'hFE00 + 16'(i)]});

        // Reset while the engine sits in RD for idx 20.
        fill_oam(8'hEE);
        dma_cycles = 0;
        cpu_write(16'hFF46, 8'hC0);
        repeat (41) tick();
        rst = 1'b0;
        #1;
        check("rst_mid_active", {15'b0, dma_active}, 16'h0000);
        check("rst_mid_wr", {15'b0, mem_wr_en}, 16'h0000);
        cpu_read_check("rst_mid_ff46", 16'hFF46, 8'hFF);
        repeat (2) tick();
        rst = 1'b1;
        repeat (20) tick();
        check("rst_stay_idle", {15'b0, dma_active}, 16'h0000);
        for (int i = 0; i < 160; i++) expect_val(i < 20 ? 16'(i) : 16'h00EE);
        for (int i = 0; i < 160; i++) pop_check("rst_oam", {8'h00, mem[16'hFE00 + 16'(i)]});
        cpu_read_check("rst_after_ff46", 16'hFF46, 8'hFF);

        check("sb_drained", 16'(sb_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
